wash_phase_timer: RTL and testbench
===================================

WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

Interface
REQ-001 The module SHALL have parameter SOAK_DUR, default 8, soak phase length in ticks (legal range 1..255).
REQ-002 The module SHALL have parameter WASH_DUR, default 12, wash1/wash2 phase length in ticks (1..255).
REQ-003 The module SHALL have parameter RINSE_DUR, default 6, rinse1/rinse2 phase length in ticks (1..255).
REQ-004 The module SHALL have parameter SPIN_DUR, default 10, spin phase length in ticks (1..255).
REQ-005 The module SHALL have parameter PRESCALE, default 4, clocks per tick; used only when WASH_PHASE_TIMER_PRESCALE_EN is defined (legal range 2..255).
REQ-006 The module SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port state, input, 3 bits: washer controller phase code (0 idle, 1 soak, 2 wash1, 3 rinse2, 4 wash2, 5 rinse1, 6 spin, 7 stop).
REQ-009 The module SHALL have port timer, output, 1 bit: one-clock phase-expired pulse fed back to the controller's timer input.
REQ-010 The module SHALL have port remaining, output, 8 bits: current countdown value.
REQ-011 The module SHALL have port busy, output, 1 bit: high while a countdown is active and not frozen.

Function
REQ-012 The module SHALL register state into last_state every clock; a "phase change" is state != last_state at a rising edge.
REQ-013 On a phase change into codes 1..6, the counter SHALL load the duration for that code (1 SOAK_DUR; 2,4 WASH_DUR; 3,5 RINSE_DUR; 6 SPIN_DUR); exception per REQ-016.
REQ-014 At each edge with no phase change, state in 1..6, counter > 0 and a tick: the counter SHALL decrement; when it decrements 1->0, timer SHALL be 1 for the following cycle only.
REQ-015 Latency: with no prescaler, the new code first sampled at edge k yields timer high in the cycle after edge k+DUR, low again after edge k+DUR+1.
REQ-016 A change 6->7 (spin->stop) SHALL freeze the counter; a change 7->6 SHALL resume from the frozen value without reload.
REQ-017 While state is 7, the counter SHALL hold and timer SHALL be 0.
REQ-018 Entry into state 0, or any phase change into 0, SHALL clear the counter to 0 with timer 0.
REQ-019 After expiry, the counter SHALL hold at 0 and timer SHALL stay 0 until the next phase change (no repeated pulses).
REQ-020 If a phase change and a 1->0 decrement coincide, the reload SHALL win and no timer pulse SHALL be produced.
REQ-021 remaining SHALL equal the counter; busy SHALL be (counter != 0) and state not in {0,7}.
REQ-022 Counter arithmetic SHALL be 8-bit unsigned and SHALL never wrap below 0.

Reset
REQ-023 When reset is high at a rising edge, counter, remaining, timer, busy SHALL be 0, last_state SHALL be 0, and the prescaler SHALL be 0; reset SHALL override all other events.
REQ-024 Reset mid-countdown SHALL abort the countdown; after reset deasserts, a nonzero state SHALL be treated as a phase change and loaded.

Configuration
REQ-025 With WASH_PHASE_TIMER_PRESCALE_EN defined, a tick SHALL occur once every PRESCALE clocks; the prescaler SHALL clear on every phase change and hold while state is 7.
REQ-026 Without WASH_PHASE_TIMER_PRESCALE_EN, every clock SHALL be a tick and no prescaler logic SHALL be present.

Verification
REQ-027 Defaults, no prescaler: reset, then state 0->1 at edge k -> remaining=8 after k, timer high exactly in the cycle after edge k+8, remaining 0 thereafter, single pulse.
REQ-028 state=6 for 4 ticks (remaining 6), then 7 for 20 clocks, then 6 -> remaining holds 6 and timer 0 during stop, pulse 6 ticks after return.
REQ-029 state 3->5 on the edge where remaining would go 1->0 -> no pulse, remaining=6 loaded.
REQ-030 Reset asserted with remaining=5 in state 2 -> next cycle remaining=0, timer=0, busy=0; release with state=2 -> reload to 12.
REQ-031 PRESCALE_EN, PRESCALE=4, state 0->4 -> remaining decrements every 4 clocks; timer pulse 48 clocks after load.
REQ-032 Closed loop with washer controller, coin pulse, double_wash=1, lid=0 -> phase sequence 1,2,3,4,5,6,0 with each phase lasting DUR+2 clocks.

Source files
------------

// File: rtl/wash_phase_timer.sv
// Phase-duration countdown timer for the washer controller: loads a duration on each phase
// change and pulses `timer` once on expiry. Define WASH_PHASE_TIMER_PRESCALE_EN for a clock prescaler.
module wash_phase_timer #(
  parameter int unsigned SOAK_DUR  = 8,
  parameter int unsigned WASH_DUR  = 12,
  parameter int unsigned RINSE_DUR = 6,
  parameter int unsigned SPIN_DUR  = 10,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] state,
  output logic       timer,
  output logic [7:0] remaining,
  output logic       busy
);

  typedef enum logic [2:0] {
    PhIdle   = 3'd0,
    PhSoak   = 3'd1,
    PhWash1  = 3'd2,
    PhRinse2 = 3'd3,
    PhWash2  = 3'd4,
    PhRinse1 = 3'd5,
    PhSpin   = 3'd6,
    PhStop   = 3'd7
  } phase_e;

  if (SOAK_DUR < 1 || SOAK_DUR > 255 || WASH_DUR < 1 || WASH_DUR > 255 ||
      RINSE_DUR < 1 || RINSE_DUR > 255 || SPIN_DUR < 1 || SPIN_DUR > 255 ||
      PRESCALE < 2 || PRESCALE > 255) begin : g_bad_param
    $error("wash_phase_timer: parameter out of range");
  end

  function automatic logic [7:0] phase_dur(input phase_e p);
    case (p)
      PhSoak:            phase_dur = 8'(SOAK_DUR);
      PhWash1, PhWash2:  phase_dur = 8'(WASH_DUR);
      PhRinse1, PhRinse2: phase_dur = 8'(RINSE_DUR);
      PhSpin:            phase_dur = 8'(SPIN_DUR);
      default:           phase_dur = 8'd0;
    endcase
  endfunction

  phase_e     phase;
  phase_e     last_state_q;
  logic [7:0] cnt_q, cnt_d;
  logic       timer_q, timer_d;
  logic       phase_change;
  logic       tick;

  assign phase        = phase_e'(state);
  assign phase_change = (phase != last_state_q);

`ifdef WASH_PHASE_TIMER_PRESCALE_EN
  logic [7:0] presc_q, presc_d;

  assign tick = (presc_q == 8'(PRESCALE - 1));

  always_comb begin
    presc_d = presc_q;
    if (phase_change) begin
      presc_d = 8'd0;
    end else if (phase != PhStop) begin
      presc_d = tick ? 8'd0 : presc_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= 8'd0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    timer_d = 1'b0;
    if (phase_change) begin
      // A phase change always beats a coinciding expiry: reload, no pulse.
      case (phase)
        PhIdle:  cnt_d = 8'd0;
        PhStop:  cnt_d = cnt_q;
        PhSpin:  if (last_state_q != PhStop) cnt_d = phase_dur(phase);
        default: cnt_d = phase_dur(phase);
      endcase
    end else if (phase == PhIdle) begin
      cnt_d = 8'd0;
    end else if (phase != PhStop && cnt_q != 8'd0 && tick) begin
      cnt_d   = cnt_q - 8'd1;
      timer_d = (cnt_q == 8'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_state_q <= PhIdle;
      cnt_q        <= 8'd0;
      timer_q      <= 1'b0;
    end else begin
      last_state_q <= phase;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
    end
  end

  assign timer     = timer_q;
  assign remaining = cnt_q;
  assign busy      = (cnt_q != 8'd0) && (phase != PhIdle) && (phase != PhStop);

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: vector table through a scoreboard queue, plus a
// closed-loop run against a small behavioural washer controller.
module tb_wash_phase_timer;

`ifdef WASH_PHASE_TIMER_PRESCALE_EN
  localparam int Scale = 4;
`else
  localparam int Scale = 1;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] state;
  logic       timer;
  logic [7:0] remaining;
  logic       busy;

  wash_phase_timer #(
    .SOAK_DUR (8),
    .WASH_DUR (12),
    .RINSE_DUR(6),
    .SPIN_DUR (10),
    .PRESCALE (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .state    (state),
    .timer    (timer),
    .remaining(remaining),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [2:0] st;
    int         cycles;
    int         rem0;
    bit         dec;
    int         tmr_at;
  } vec_t;

  typedef struct {
    logic [7:0] rem;
    logic       tmr;
    logic       bsy;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: output produced with empty expectation queue");
      return;
    end
    e = sb.pop_front();
    if (remaining !== e.rem || timer !== e.tmr || busy !== e.bsy) begin
      errors++;
      $display("FAIL vec%0d: got remaining=%0d timer=%0b busy=%0b, want remaining=%0d timer=%0b busy=%0b",
               e.tag, remaining, timer, busy, e.rem, e.tmr, e.bsy);
    end
  endtask

  task automatic drive_cycle(input logic r, input logic [2:0] s, input int er, input logic et,
                             input int tag);
    exp_t e;
    reset = r;
    state = s;
    e.rem = 8'(er);
    e.tmr = et;
    e.bsy = (er != 0) && (s != 3'd0) && (s != 3'd7);
    e.tag = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  vec_t vecs[$];
  int   durs[7];

  initial begin
    int rem;
    int cnt;
    int code;
    bit pending;
    bit done;

    reset = 1'b1;
    state = 3'd0;
    durs  = '{0, 8, 12, 6, 12, 6, 10};

`ifdef WASH_PHASE_TIMER_PRESCALE_EN
    drive_cycle(1'b1, 3'd0, 0, 1'b0, 0);
    drive_cycle(1'b0, 3'd0, 0, 1'b0, 1);
    for (int c = 0; c < 52; c++) begin
      rem = (c >= 48) ? 0 : 12 - c / 4;
      drive_cycle(1'b0, 3'd4, rem, c == 48, 100 + c);
    end
`else
    //             rst   st    cyc rem0 dec tmr_at
    vecs.push_back('{1'b1, 3'd0, 2,  0,   0, -1});  // reset
    vecs.push_back('{1'b0, 3'd0, 2,  0,   0, -1});  // idle
    vecs.push_back('{1'b0, 3'd1, 12, 8,   1, 8});   // soak, single pulse, hold at 0
    vecs.push_back('{1'b0, 3'd6, 5,  10,  1, -1});  // spin down to 6
    vecs.push_back('{1'b0, 3'd7, 20, 6,   0, -1});  // stop freezes
    vecs.push_back('{1'b0, 3'd6, 8,  6,   1, 6});   // resume without reload
    vecs.push_back('{1'b0, 3'd3, 6,  6,   1, -1});  // rinse2 down to 1
    vecs.push_back('{1'b0, 3'd5, 8,  6,   1, 6});   // change on 1->0 edge: reload wins
    vecs.push_back('{1'b0, 3'd2, 8,  12,  1, -1});  // wash1 down to 5
    vecs.push_back('{1'b1, 3'd2, 1,  0,   0, -1});  // reset mid-countdown
    vecs.push_back('{1'b0, 3'd2, 3,  12,  1, -1});  // release: reload 12
    vecs.push_back('{1'b0, 3'd0, 2,  0,   0, -1});  // idle clears
    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) begin
        rem = vecs[i].dec ? ((vecs[i].rem0 - c > 0) ? vecs[i].rem0 - c : 0) : vecs[i].rem0;
        drive_cycle(vecs[i].rst, vecs[i].st, rem, c == vecs[i].tmr_at, i);
      end
    end
`endif

    // Closed loop: controller advances on a sampled timer pulse, 1..6 then back to idle.
    reset = 1'b1;
    state = 3'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    code    = 1;
    state   = 3'd1;
    cnt     = 0;
    pending = 1'b0;
    done    = 1'b0;
    for (int it = 0; it < 1000 && !done; it++) begin
      @(posedge clock);
      #1;
      cnt++;
      if (pending) begin
        checks++;
        if (cnt != durs[code] * Scale + 2) begin
          errors++;
          $display("FAIL loop_phase%0d: lasted %0d clocks, want %0d", code, cnt,
                   durs[code] * Scale + 2);
        end
        code    = (code == 6) ? 0 : code + 1;
        state   = 3'(code);
        cnt     = 0;
        pending = 1'b0;
        done    = (code == 0);
      end else if (timer) begin
        pending = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL loop_timeout: stuck in phase %0d, want return to phase 0", code);
    end
    @(posedge clock);
    #1;
    checks++;
    if (remaining !== 8'd0 || timer !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_idle: got remaining=%0d timer=%0b busy=%0b, want 0 0 0",
               remaining, timer, busy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
